// File: rtl/io_uart.sv
// io_uart: memory-mapped UART on the core's 8-bit I/O bus.
// 4-entry TX FIFO feeding a serialiser, single-entry RX buffer behind a
// 2-flop synchronised deserialiser, programmable baud divisor (bit = DIV+1 clocks).
module io_uart #(
    parameter logic [7:0]  BASE      = 8'h10,
    parameter logic [15:0] DIV_RESET = 16'd867,
    parameter int unsigned TXQ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetb,
    input  logic [7:0]  io_addr,
    input  logic        io_en,
    input  logic        io_we,
    input  logic [31:0] io_data_write,
    output logic [31:0] io_data_read,
    output logic        sel,
    output logic        uart_tx,
    input  logic        uart_rx
);
    localparam int unsigned AW = $clog2(TXQ_DEPTH);
    localparam logic [AW:0] QCNT_FULL = (AW+1)'(TXQ_DEPTH);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    // Bus decode
    logic [1:0]  w_off;
    logic        w_rd, w_wr, w_wr_data, w_wr_div, w_rd_data, w_rd_status;
    logic        w_unused_bus;

    assign sel         = io_en && (io_addr[7:4] == BASE[7:4]);
    assign w_off       = io_addr[3:2];
    assign w_rd        = sel && !io_we;
    assign w_wr        = sel && io_we;
    assign w_wr_data   = w_wr && (w_off == 2'd0);
    assign w_wr_div    = w_wr && (w_off == 2'd2);
    assign w_rd_data   = w_rd && (w_off == 2'd0);
    assign w_rd_status = w_rd && (w_off == 2'd1);
    assign w_unused_bus = ^{io_data_write[31:16], io_addr[1:0]};

    // Registers
    logic [15:0]   r_div;
    logic [7:0]    r_txq [TXQ_DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [AW:0]   r_count;
    logic [7:0]    r_rx_byte;
    logic          r_rx_valid, r_rx_overrun;

    logic w_full, w_empty, w_push, w_pop, w_tx_busy, w_rx_done;

    assign w_full  = (r_count == QCNT_FULL);
    assign w_empty = (r_count == '0);
    // A write while full still lands if the serialiser pops in the same cycle.
    assign w_push  = w_wr_data && (!w_full || w_pop);

    // TX state
    state_e      r_tx_state, w_tx_state_d;
    logic [15:0] r_tx_cnt, w_tx_cnt_d;
    logic [2:0]  r_tx_bit, w_tx_bit_d;
    logic [7:0]  r_tx_shift, w_tx_shift_d;
    logic        r_tx_line, w_tx_line_d;

    // RX state
    state_e      r_rx_state, w_rx_state_d;
    logic [15:0] r_rx_cnt, w_rx_cnt_d;
    logic [2:0]  r_rx_bit, w_rx_bit_d;
    logic [7:0]  r_rx_shift, w_rx_shift_d;
    logic        r_rx_s1, r_rx_s2, r_rx_prev;
    logic [15:0] w_rx_half;

    assign w_tx_busy = (r_tx_state != StIdle);
    assign uart_tx   = r_tx_line;
    assign w_rx_half = 16'((17'(r_div) + 17'd1) >> 1);

    // Divisor, FIFO pointers/count and RX buffer flags
    always_ff @(posedge clk) begin
        if (!resetb) begin
            r_div        <= DIV_RESET;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_rx_byte    <= '0;
            r_rx_valid   <= 1'b0;
            r_rx_overrun <= 1'b0;
        end else begin
            if (w_wr_div) r_div <= io_data_write[15:0];
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // A completing frame wins over a DATA read clearing rx_valid.
            if (w_rx_done) begin
                r_rx_byte  <= r_rx_shift;
                r_rx_valid <= 1'b1;
            end else if (w_rd_data) begin
                r_rx_valid <= 1'b0;
            end
            if (w_rx_done && r_rx_valid && !w_rd_data) begin
                r_rx_overrun <= 1'b1;
            end else if (w_rd_status) begin
                r_rx_overrun <= 1'b0;
            end
        end
    end

    // FIFO storage; contents are don't-care while the pointers say empty
    always_ff @(posedge clk) begin
        if (w_push) r_txq[r_wptr] <= io_data_write[7:0];
    end

    // TX and RX state registers plus the input synchroniser
    always_ff @(posedge clk) begin
        if (!resetb) begin
            r_tx_state <= StIdle;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_line  <= 1'b1;
            r_rx_state <= StIdle;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_prev  <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_d;
            r_tx_cnt   <= w_tx_cnt_d;
            r_tx_bit   <= w_tx_bit_d;
            r_tx_shift <= w_tx_shift_d;
            r_tx_line  <= w_tx_line_d;
            r_rx_state <= w_rx_state_d;
            r_rx_cnt   <= w_rx_cnt_d;
            r_rx_bit   <= w_rx_bit_d;
            r_rx_shift <= w_rx_shift_d;
            r_rx_s1    <= uart_rx;
            r_rx_s2    <= r_rx_s1;
            r_rx_prev  <= r_rx_s2;
        end
    end

    // TX next state; the baud counter reloads from r_div so divisor writes hit the next bit
    always_comb begin
        w_tx_state_d = r_tx_state;
        w_tx_cnt_d   = r_tx_cnt;
        w_tx_bit_d   = r_tx_bit;
        w_tx_shift_d = r_tx_shift;
        w_pop        = 1'b0;
        case (r_tx_state)
            StIdle: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_tx_shift_d = r_txq[r_rptr];
                    w_tx_cnt_d   = r_div;
                    w_tx_state_d = StStart;
                end
            end
            StStart: begin
                if (r_tx_cnt == '0) begin
                    w_tx_cnt_d   = r_div;
                    w_tx_bit_d   = '0;
                    w_tx_state_d = StData;
                end else begin
                    w_tx_cnt_d = r_tx_cnt - 16'd1;
                end
            end
            StData: begin
                if (r_tx_cnt == '0) begin
                    w_tx_cnt_d   = r_div;
                    w_tx_shift_d = {1'b0, r_tx_shift[7:1]};
                    if (r_tx_bit == 3'd7) w_tx_state_d = StStop;
                    else w_tx_bit_d = r_tx_bit + 3'd1;
                end else begin
                    w_tx_cnt_d = r_tx_cnt - 16'd1;
                end
            end
            StStop: begin
                if (r_tx_cnt == '0) begin
                    // Chain straight into the next start bit so queued frames have no gap.
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_tx_shift_d = r_txq[r_rptr];
                        w_tx_cnt_d   = r_div;
                        w_tx_state_d = StStart;
                    end else begin
                        w_tx_state_d = StIdle;
                    end
                end else begin
                    w_tx_cnt_d = r_tx_cnt - 16'd1;
                end
            end
            default: w_tx_state_d = StIdle;
        endcase
        case (w_tx_state_d)
            StStart: w_tx_line_d = 1'b0;
            StData:  w_tx_line_d = w_tx_shift_d[0];
            default: w_tx_line_d = 1'b1;
        endcase
    end

    // RX next state; every sample is taken when the counter hits zero
    always_comb begin
        w_rx_state_d = r_rx_state;
        w_rx_cnt_d   = r_rx_cnt;
        w_rx_bit_d   = r_rx_bit;
        w_rx_shift_d = r_rx_shift;
        w_rx_done    = 1'b0;
        case (r_rx_state)
            StIdle: begin
                if (r_rx_prev && !r_rx_s2) begin
                    w_rx_cnt_d   = w_rx_half;
                    w_rx_state_d = StStart;
                end
            end
            StStart: begin
                if (r_rx_cnt == '0) begin
                    if (r_rx_s2) begin
                        w_rx_state_d = StIdle;
                    end else begin
                        w_rx_cnt_d   = r_div;
                        w_rx_bit_d   = '0;
                        w_rx_state_d = StData;
                    end
                end else begin
                    w_rx_cnt_d = r_rx_cnt - 16'd1;
                end
            end
            StData: begin
                if (r_rx_cnt == '0) begin
                    w_rx_cnt_d   = r_div;
                    w_rx_shift_d = {r_rx_s2, r_rx_shift[7:1]};
                    if (r_rx_bit == 3'd7) w_rx_state_d = StStop;
                    else w_rx_bit_d = r_rx_bit + 3'd1;
                end else begin
                    w_rx_cnt_d = r_rx_cnt - 16'd1;
                end
            end
            StStop: begin
                if (r_rx_cnt == '0) begin
                    // Low stop bit is a framing error: drop the byte silently.
                    w_rx_done    = r_rx_s2;
                    w_rx_state_d = StIdle;
                end else begin
                    w_rx_cnt_d = r_rx_cnt - 16'd1;
                end
            end
            default: w_rx_state_d = StIdle;
        endcase
    end

    // Zero-wait-state read mux
    always_comb begin
        io_data_read = '0;
        if (w_rd) begin
            case (w_off)
                2'd0:    io_data_read = {24'b0, r_rx_byte};
                2'd1:    io_data_read = {27'b0, r_rx_overrun, r_rx_valid, w_tx_busy,
                                         w_empty, w_full};
                2'd2:    io_data_read = {16'b0, r_div};
                default: io_data_read = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_io_uart.sv
// Bench for io_uart: stimulus pushes expected bus reads and TX frames into
// queues; independent monitors pop and compare when the DUT presents them.
module tb_io_uart;
    logic        clk;
    logic        resetb;
    logic [7:0]  io_addr;
    logic        io_en;
    logic        io_we;
    logic [31:0] io_data_write;
    logic [31:0] io_data_read;
    logic        sel;
    logic        uart_tx;
    logic        uart_rx;

    io_uart dut (
        .clk           (clk),
        .resetb        (resetb),
        .io_addr       (io_addr),
        .io_en         (io_en),
        .io_we         (io_we),
        .io_data_write (io_data_write),
        .io_data_read  (io_data_read),
        .sel           (sel),
        .uart_tx       (uart_tx),
        .uart_rx       (uart_rx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [32:0] val;
        string       name;
    } rd_exp_t;

    typedef struct {
        logic [7:0] data;
        bit         b2b;
    } tx_exp_t;

    rd_exp_t     rd_q[$];
    tx_exp_t     tx_q[$];
    int unsigned tb_div = 867;
    bit          mon_en = 1'b1;

    task automatic check(input bit ok, input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Read monitor: compares {sel, io_data_read} during every read access.
    initial begin
        rd_exp_t e;
        forever begin
            @(negedge clk);
            if (io_en === 1'b1 && io_we === 1'b0) begin
                if (rd_q.size() == 0) begin
                    check(1'b0, "rd_unexpected", {31'b0, sel, io_data_read}, 0);
                end else begin
                    e = rd_q.pop_front();
                    check({sel, io_data_read} === e.val, e.name,
                          {31'b0, sel, io_data_read}, {31'b0, e.val});
                end
            end
        end
    end

    // TX monitor: checks every cycle of each frame against the expected byte.
    initial begin
        tx_exp_t     e;
        logic [9:0]  frame;
        bit          busy;
        int unsigned pos;
        int          bad_bits;
        int          last_end;
        busy     = 1'b0;
        last_end = -100;
        pos      = 0;
        bad_bits = 0;
        frame    = '1;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                busy = 1'b0;
            end else begin
                if (!busy && uart_tx === 1'b0) begin
                    busy     = 1'b1;
                    pos      = 0;
                    bad_bits = 0;
                    if (tx_q.size() == 0) begin
                        check(1'b0, "tx_unexpected_frame", 0, 1);
                        frame = '1;
                    end else begin
                        e     = tx_q.pop_front();
                        frame = {1'b1, e.data, 1'b0};
                        if (e.b2b) check(cyc == last_end + 1, "tx_gap", cyc, last_end + 1);
                    end
                end
                if (busy) begin
                    if (uart_tx !== frame[pos / (tb_div + 1)]) bad_bits++;
                    pos++;
                    if (pos == 10 * (tb_div + 1)) begin
                        busy     = 1'b0;
                        last_end = cyc;
                        check(bad_bits == 0, "tx_frame", {54'b0, frame}, {54'b0, frame});
                        if (bad_bits != 0) $display("  frame byte %0h had %0d bad cycles",
                                                    frame[8:1], bad_bits);
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        io_en = 1'b1; io_we = 1'b1; io_addr = a; io_data_write = d;
        @(posedge clk); #1;
        io_en = 1'b0; io_we = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, input logic s, input logic [31:0] exp,
                            input string name);
        rd_exp_t e;
        e.val  = {s, exp};
        e.name = name;
        rd_q.push_back(e);
        io_en = 1'b1; io_we = 1'b0; io_addr = a;
        @(posedge clk); #1;
        io_en = 1'b0;
    endtask

    task automatic push_tx(input logic [7:0] d, input bit b2b);
        tx_exp_t e;
        e.data = d;
        e.b2b  = b2b;
        tx_q.push_back(e);
    endtask

    task automatic send_rx(input logic [7:0] b);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = f[i];
            repeat (tb_div + 1) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetb = 1'b0; io_en = 1'b0; io_we = 1'b0; io_addr = '0; io_data_write = '0;
        uart_rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check(uart_tx === 1'b1, "rst_tx_idle", {63'b0, uart_tx}, 1);
        resetb = 1'b1;
        bus_read(8'h14, 1'b1, 32'h02, "rst_status");
        bus_read(8'h18, 1'b1, 32'd867, "rst_div");
        bus_read(8'h10, 1'b1, 32'h00, "rst_data");
        bus_read(8'h1C, 1'b1, 32'h00, "reserved");
        bus_read(8'h24, 1'b0, 32'h00, "unselected");
        bus_write(8'h14, 32'hFF);
        bus_write(8'h1C, 32'hFF);
        bus_read(8'h14, 1'b1, 32'h02, "status_write_ignored");

        // Single frame at DIV=3
        bus_write(8'h18, 32'd3);
        tb_div = 3;
        bus_read(8'h18, 1'b1, 32'd3, "div_readback");
        push_tx(8'h55, 1'b0);
        bus_write(8'h10, 32'h55);
        idle(5);
        bus_read(8'h14, 1'b1, 32'h06, "tx_busy_status");
        idle(45);
        bus_read(8'h14, 1'b1, 32'h02, "tx_done_status");

        // Five back-to-back writes: the first pops at once, so all five fit
        push_tx(8'hA1, 1'b0); bus_write(8'h10, 32'hA1);
        push_tx(8'hB2, 1'b1); bus_write(8'h10, 32'hB2);
        push_tx(8'hC3, 1'b1); bus_write(8'h10, 32'hC3);
        push_tx(8'hD4, 1'b1); bus_write(8'h10, 32'hD4);
        push_tx(8'hE5, 1'b1); bus_write(8'h10, 32'hE5);
        bus_read(8'h14, 1'b1, 32'h05, "fifo_full");
        bus_write(8'h10, 32'hF6);   // dropped: FIFO full, no pop this cycle
        idle(220);
        bus_read(8'h14, 1'b1, 32'h02, "fifo_drained");

        // RX at DIV=7
        bus_write(8'h18, 32'd7);
        tb_div = 7;
        send_rx(8'h3C);
        idle(4);
        bus_read(8'h14, 1'b1, 32'h0A, "rx_valid");
        bus_read(8'h10, 1'b1, 32'h3C, "rx_data");
        bus_read(8'h14, 1'b1, 32'h02, "rx_valid_cleared");
        send_rx(8'h11);
        send_rx(8'h22);
        idle(4);
        bus_read(8'h14, 1'b1, 32'h1A, "rx_overrun");
        bus_read(8'h10, 1'b1, 32'h22, "rx_overwrite_data");
        bus_read(8'h14, 1'b1, 32'h02, "rx_overrun_cleared");
        uart_rx = 1'b0;
        idle(2);
        uart_rx = 1'b1;
        idle(30);
        bus_read(8'h14, 1'b1, 32'h02, "rx_false_start");

        // Reset in the middle of a frame of zero bits
        bus_write(8'h18, 32'd3);
        tb_div = 3;
        mon_en = 1'b0;
        bus_write(8'h10, 32'h00);
        bus_write(8'h10, 32'h00);
        idle(12);
        check(uart_tx === 1'b0, "tx_low_mid_frame", {63'b0, uart_tx}, 0);
        resetb = 1'b0;
        idle(1);
        check(uart_tx === 1'b1, "tx_reset_abort", {63'b0, uart_tx}, 1);
        resetb = 1'b1;
        bus_read(8'h14, 1'b1, 32'h02, "post_reset_status");
        bus_read(8'h18, 1'b1, 32'd867, "post_reset_div");
        idle(2);
        mon_en = 1'b1;
        idle(60);

        check(tx_q.size() == 0, "tx_queue_drained", tx_q.size(), 0);
        check(rd_q.size() == 0, "rd_queue_drained", rd_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
